// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the asynchronous FIFO.
// Gray/binary conversions work on a zero-extended vector of up to GRAY_MAX_W bits.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int GRAY_MAX_W    = 16;

    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ostate_t;

    function automatic int depth_of(input int ptr_width);
        return 1 << ptr_width;
    endfunction

    localparam int DEPTH_DEF = depth_of(PTR_WIDTH_DEF);

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits stay zero, so any narrower pointer converts correctly.
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary + Gray pointer register with increment enable.
// Shared by the read- and write-side FIFO controllers.
module fifo_gray_ptr
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] nxt
);

    assign nxt = bin + W'(inc);

    // Advance both encodings together so Gray always matches binary.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= nxt;
            gray <= W'(bin2gray(GRAY_MAX_W'(nxt)));
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointer, EMPTY, level,
// and a registered valid/ready output stage fed from the FIFO memory.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = PTR_WIDTH_DEF
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [PTR_WIDTH:0]    WPTR_GRAY_SYNC,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    input  logic                  O_READY,
    output logic                  R_EN,
    output logic [PTR_WIDTH-1:0]  B_RPTR,
    output logic [PTR_WIDTH:0]    RPTR_GRAY,
    output logic                  EMPTY,
    output logic                  O_VALID,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic [PTR_WIDTH:0]    R_LEVEL
);

    localparam int PW = PTR_WIDTH + 1;

    logic          pop;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] rgray_next;
    ostate_t       state;
    ostate_t       state_nxt;

    // Pop whenever memory has data and the output slot is free or draining.
    assign pop  = !EMPTY && (!O_VALID || O_READY);
    assign R_EN = pop;

    fifo_gray_ptr #(
        .W (PW)
    ) u_rptr (
        .clk  (R_CLK),
        .rst  (R_RST),
        .inc  (pop),
        .bin  (rptr_bin),
        .gray (rptr_gray),
        .nxt  (rptr_next)
    );

    assign B_RPTR     = rptr_bin[PTR_WIDTH-1:0];
    assign RPTR_GRAY  = rptr_gray;
    assign wptr_bin   = PW'(gray2bin(GRAY_MAX_W'(WPTR_GRAY_SYNC)));
    assign rgray_next = PW'(bin2gray(GRAY_MAX_W'(rptr_next)));

    // Flags track the post-pop pointer so the last word is never over-read.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            EMPTY   <= 1'b1;
            R_LEVEL <= '0;
        end else begin
            EMPTY   <= (rgray_next == WPTR_GRAY_SYNC);
            R_LEVEL <= wptr_bin - rptr_bin - PW'(pop);
        end
    end

    // Output stage state register.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output stage next-state: fill on pop, empty on a transfer without refill.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (pop) state_nxt = HOLD;
            HOLD: if (O_READY && !pop) state_nxt = IDLE;
        endcase
    end

    // Output stage decode.
    always_comb begin
        O_VALID = (state == HOLD);
    end

    // Output word loads only on a pop; it is otherwise held.
    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            O_DATA <= '0;
        end else if (pop) begin
            O_DATA <= MEM_RDATA;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a write-side model,
// a behavioural memory and a data scoreboard.
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int PTRW  = 3;
    localparam int W     = PTRW + 1;
    localparam int DEPTH = 8;

    typedef struct {
        logic          rdy;
        logic          vld;
        logic [DW-1:0] dat;
        logic          emp;
        logic [W-1:0]  lvl;
        logic          ren;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    wsync = '0;
    logic [DW-1:0]   mem_rdata;
    logic            o_ready = 1'b0;
    logic            r_en;
    logic [PTRW-1:0] b_rptr;
    logic [W-1:0]    rptr_gray;
    logic            empty;
    logic            o_valid;
    logic [DW-1:0]   o_data;
    logic [W-1:0]    r_level;

    logic [DW-1:0] mem [DEPTH];
    logic [W-1:0]  wptr = '0;
    logic [DW-1:0] q [$];
    vec_t          tbl [9];
    int            errors = 0;
    int            checks = 0;
    logic          held = 1'b0;
    logic [DW-1:0] hdata = '0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[b_rptr];

    fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (PTRW)
    ) dut (
        .R_CLK          (clk),
        .R_RST          (rst),
        .WPTR_GRAY_SYNC (wsync),
        .MEM_RDATA      (mem_rdata),
        .O_READY        (o_ready),
        .R_EN           (r_en),
        .B_RPTR         (b_rptr),
        .RPTR_GRAY      (rptr_gray),
        .EMPTY          (empty),
        .O_VALID        (o_valid),
        .O_DATA         (o_data),
        .R_LEVEL        (r_level)
    );

    function automatic logic [W-1:0] gray(input logic [W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wptr[PTRW-1:0]] = d;
        q.push_back(d);
        wptr  = wptr + 1'b1;
        wsync = gray(wptr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            held = 1'b0;
        end else begin
            chk("ren_rule", 32'(r_en),
                32'(!empty && (!o_valid || o_ready)));
            chk("level_max", 32'(r_level <= W'(DEPTH)), 32'd1);
            if (held) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(hdata));
            end
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got %0h expected none",
                             o_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", 32'(o_data), 32'(e));
                end
            end
            held  = o_valid && !o_ready;
            hdata = o_data;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        tbl[0] = '{1'b0, 1'b0, 8'hA5, 1'b0, 4'd3, 1'b1};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{1'b0, 1'b1, 8'h11, 1'b0, 4'd2, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h22, 1'b0, 4'd1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 8'h33, 1'b1, 4'd0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 8'h33, 1'b1, 4'd0, 1'b0};

        // Reset
        rst = 1'b1;
        wsync = '0;
        o_ready = 1'b0;
        repeat (2) begin
            step();
            chk("rst_ren", 32'(r_en), 32'd0);
        end
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_gray", 32'(rptr_gray), 32'd0);
        chk("rst_level", 32'(r_level), 32'd0);
        rst = 1'b0;

        // Single word
        o_ready = 1'b1;
        push(8'hA5);
        step();
        chk("sw_empty_k", 32'(empty), 32'd0);
        chk("sw_ren_k", 32'(r_en), 32'd1);
        chk("sw_valid_k", 32'(o_valid), 32'd0);
        chk("sw_level_k", 32'(r_level), 32'd1);
        step();
        chk("sw_valid_k1", 32'(o_valid), 32'd1);
        chk("sw_data_k1", 32'(o_data), 32'hA5);
        chk("sw_gray_k1", 32'(rptr_gray), 32'd1);
        chk("sw_empty_k1", 32'(empty), 32'd1);
        chk("sw_level_k1", 32'(r_level), 32'd0);
        step();
        chk("sw_valid_done", 32'(o_valid), 32'd0);

        // Backpressure, table driven
        push(8'h11);
        push(8'h22);
        push(8'h33);
        for (int i = 0; i < 9; i++) begin
            o_ready = tbl[i].rdy;
            step();
            chk($sformatf("bp%0d_valid", i), 32'(o_valid), 32'(tbl[i].vld));
            chk($sformatf("bp%0d_data", i), 32'(o_data), 32'(tbl[i].dat));
            chk($sformatf("bp%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("bp%0d_level", i), 32'(r_level), 32'(tbl[i].lvl));
            chk($sformatf("bp%0d_ren", i), 32'(r_en), 32'(tbl[i].ren));
        end

        // Mid-operation reset
        o_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        step();
        chk("mr_level5", 32'(r_level), 32'd5);
        step();
        chk("mr_valid", 32'(o_valid), 32'd1);
        chk("mr_level4", 32'(r_level), 32'd4);
        rst = 1'b1;
        step();
        chk("mr_rst_valid", 32'(o_valid), 32'd0);
        chk("mr_rst_empty", 32'(empty), 32'd1);
        chk("mr_rst_gray", 32'(rptr_gray), 32'd0);
        chk("mr_rst_data", 32'(o_data), 32'd0);
        chk("mr_rst_level", 32'(r_level), 32'd0);
        rst = 1'b0;
        wptr = '0;
        wsync = '0;
        q.delete();
        step();
        chk("mr_post_empty", 32'(empty), 32'd1);
        chk("mr_post_valid", 32'(o_valid), 32'd0);

        // Full drain, then a second lap that wraps the pointer
        o_ready = 1'b1;
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 0; i < DEPTH; i++)
                push(8'((lap == 0 ? 8'h80 : 8'hC0) + i));
            step();
            chk("fd_empty0", 32'(empty), 32'd0);
            for (int i = 0; i < DEPTH; i++) begin
                chk("fd_addr", 32'(b_rptr), 32'(i));
                chk("fd_level", 32'(r_level), 32'(DEPTH - i));
                chk("fd_ren", 32'(r_en), 32'd1);
                step();
            end
            chk("fd_gray", 32'(rptr_gray), 32'(lap == 0 ? 4'd12 : 4'd0));
            chk("fd_empty1", 32'(empty), 32'd1);
            chk("fd_level0", 32'(r_level), 32'd0);
            chk("fd_addr_end", 32'(b_rptr), 32'd0);
            chk("fd_last", 32'(o_data),
                32'(lap == 0 ? 8'h87 : 8'hC7));
            step();
            chk("fd_idle", 32'(o_valid), 32'd0);
        end

        // Streaming, one word per cycle
        for (int i = 0; i < 20; i++) begin
            push(8'(i * 7 + 3));
            step();
            if (i >= 1) chk("st_valid", 32'(o_valid), 32'd1);
        end
        repeat (4) step();
        chk("st_drained_q", 32'(q.size()), 32'd0);
        chk("st_idle", 32'(o_valid), 32'd0);
        chk("st_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
